// File: rtl/kv_lookup_table.sv
// ============================================================================
//  Module   : kv_lookup_table
//  Brief    : Run-time programmable key/value table with a registered
//             valid/ready lookup port and a single-cycle command port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kv_lookup_table #(
    parameter int KEY_NUM     = 4,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 0,
    localparam int CNT_W      = $clog2(KEY_NUM + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    input  logic [KEY_LEN-1:0]  cmd_key,
    input  logic [DATA_LEN-1:0] cmd_data,
    output logic                cmd_err,
    input  logic                lk_valid,
    output logic                lk_ready,
    input  logic [KEY_LEN-1:0]  lk_key,
    input  logic [DATA_LEN-1:0] default_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic [CNT_W-1:0]    count,
    output logic                full
);

    localparam int IDX_W = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;

    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_DEL   = 2'b10;
    localparam logic [1:0] c_OP_CLR   = 2'b11;

    logic [KEY_NUM-1:0]  r_valid;
    logic [KEY_LEN-1:0]  r_key  [KEY_NUM];
    logic [DATA_LEN-1:0] r_data [KEY_NUM];
    logic [CNT_W-1:0]    r_count;
    logic                r_full;
    logic                r_cmd_err;
    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic [DATA_LEN-1:0] r_rsp_data;

    logic                w_cmd_hit;
    logic [IDX_W-1:0]    w_cmd_idx;
    logic                w_free_found;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_lk_hit;
    logic [DATA_LEN-1:0] w_lk_data;
    logic                w_do_write;
    logic                w_do_del;
    logic                w_do_clr;
    logic                w_alloc;
    logic                w_upd;
    logic                w_del;
    logic                w_err_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_lk_accept;
    logic [DATA_LEN-1:0] w_miss_data;

    // Descending scan so the lowest matching / free index is the last one kept.
    always_comb begin
        w_cmd_hit    = 1'b0;
        w_cmd_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_lk_hit     = 1'b0;
        w_lk_data    = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_key[i] == cmd_key)) begin
                w_cmd_hit = 1'b1;
                w_cmd_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (r_valid[i] && (r_key[i] == lk_key)) begin
                w_lk_hit  = 1'b1;
                w_lk_data = r_data[i];
            end
        end
    end

    assign w_do_write = cmd_valid && (cmd_op == c_OP_WRITE);
    assign w_do_del   = cmd_valid && (cmd_op == c_OP_DEL);
    assign w_do_clr   = cmd_valid && (cmd_op == c_OP_CLR);
    assign w_upd      = w_do_write && w_cmd_hit;
    assign w_alloc    = w_do_write && !w_cmd_hit && w_free_found;
    assign w_del      = w_do_del && w_cmd_hit;
    assign w_err_nxt  = (w_do_write && !w_cmd_hit && !w_free_found) ||
                        (w_do_del && !w_cmd_hit);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_clr) begin
            w_count_nxt = '0;
        end else if (w_alloc) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_del) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Key/data payload needs no reset; validity lives in r_valid.
    always_ff @(posedge clk) begin
        if (w_upd) begin
            r_data[w_cmd_idx] <= cmd_data;
        end
        if (w_alloc) begin
            r_key[w_free_idx]  <= cmd_key;
            r_data[w_free_idx] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            if (w_do_clr) begin
                r_valid <= '0;
            end else begin
                if (w_alloc) begin
                    r_valid[w_free_idx] <= 1'b1;
                end
                if (w_del) begin
                    r_valid[w_cmd_idx] <= 1'b0;
                end
            end
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == CNT_W'(KEY_NUM));
            r_cmd_err <= w_err_nxt;
        end
    end

    assign lk_ready    = !r_rsp_valid || rsp_ready;
    assign w_lk_accept = lk_valid && lk_ready;
    assign w_miss_data = (HAS_DEFAULT != 0) ? default_data : '0;

    // Response sees pre-edge table contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_lk_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= w_lk_hit;
            r_rsp_data  <= w_lk_hit ? w_lk_data : w_miss_data;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_err   = r_cmd_err;
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_data  = r_rsp_data;
    assign count     = r_count;
    assign full      = r_full;

endmodule

`default_nettype wire
